multdiv_issue: RTL and testbench

MULTDIV_ISSUE -- requirements
Module: multdiv_issue

---
 rtl/multdiv_issue.sv | 150 +++++++++++++++
 tb/tb_multdiv_issue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer for an external multiply/divide unit: latches a request,
// pulses the unit, waits (with timeout) for its result and strobes a single writeback.
module multdiv_issue #(
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    input  logic        unit_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int          CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [4:0]  RSTATUS = 5'(RSTATUS_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [4:0]    rd_q, rd_d;
    logic          is_div_q, is_div_d;
    logic [31:0]   res_q, res_d;
    logic          exc_q, exc_d;
    logic          boot_q;
    logic          accept;

    // The cycle right after reset refuses new work so the pipeline sees a quiet interface.
    assign accept = (start_mult | start_div) & ~boot_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            boot_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            boot_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        exc_d    = exc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = operand_a;
                    b_d      = operand_b;
                    rd_d     = rd_in;
                    is_div_d = ~start_mult;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Any ready seen here belongs to the previous operation.
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (unit_resultRDY) begin
                    res_d   = unit_result;
                    exc_d   = unit_exception;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    exc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        unit_a    = '0;
        unit_b    = '0;
        if (!reset) begin
            unit_a    = a_q;
            unit_b    = b_q;
            ctrl_MULT = (state_q == ISSUE) & ~is_div_q;
            ctrl_DIV  = (state_q == ISSUE) & is_div_q;
            stall     = ((state_q == IDLE) & accept) | (state_q == ISSUE) | (state_q == WAIT);
            if (state_q == DONE) begin
                if (exc_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = RSTATUS;
                    wb_data  = is_div_q ? 32'd5 : 32'd4;
                end else if (rd_q != 5'd0) begin
                    wb_valid = 1'b1;
                    wb_rd    = rd_q;
                    wb_data  = res_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Randomized scoreboard bench for multdiv_issue: the driver plays execute stage and the
// mult/div unit, pushes expected writebacks; a monitor pops and compares on wb_valid.
module tb_multdiv_issue;

    localparam int         TIMEOUT = 40;
    localparam logic [4:0] RSTATUS = 5'd30;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic [31:0] unit_result;
    logic        unit_exception, unit_resultRDY;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] unit_a, unit_b;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  mult_pulses = 0;
    int  div_pulses  = 0;

    multdiv_issue #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .unit_result(unit_result), .unit_exception(unit_exception),
        .unit_resultRDY(unit_resultRDY),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .unit_a(unit_a), .unit_b(unit_b), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic any_out();
        return ctrl_MULT | ctrl_DIV | stall | wb_valid | (|wb_rd) | (|wb_data)
             | (|unit_a) | (|unit_b);
    endfunction

    // Monitor: compares every writeback against the scoreboard.
    initial begin
        wb_t e;
        forever begin
            @(negedge clock);
            if (ctrl_MULT) mult_pulses++;
            if (ctrl_DIV) div_pulses++;
            if (ctrl_MULT && ctrl_DIV) chk("ctrl_exclusive", 64'(1), 64'(0));
            if (wb_valid) begin
                chk("stall_in_done", 64'(stall), 64'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                end
            end else if (wb_rd != 5'd0 || wb_data != 32'd0) begin
                chk("wb_zero_when_idle", 64'({wb_rd, wb_data}), 64'(0));
            end
        end
    end

    // lat = WAIT cycle on which the unit answers; 0 means it never answers.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int lat,
                          input bit stale, input bit restart);
        logic        is_div;
        logic [31:0] res;
        logic        exc;
        int          n, wait_len;
        is_div = d && !m;
        res    = is_div ? ((b != 0) ? a / b : 32'hFFFF_FFFF) : a * b;
        exc    = is_div && (b == 0);
        mult_pulses = 0;
        div_pulses  = 0;
        start_mult = m;
        start_div  = d;
        operand_a  = a;
        operand_b  = b;
        rd_in      = rd;
        if (stale) begin
            unit_resultRDY = 1'b1;
            unit_result    = ~res;
            unit_exception = 1'b0;
        end
        if (lat == 0 || exc) exp_q.push_back({RSTATUS, is_div ? 32'd5 : 32'd4});
        else if (rd != 5'd0) exp_q.push_back({rd, res});
        @(negedge clock);
        chk("stall_on_start", 64'(stall), 64'(1));
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        rd_in      = 5'($urandom);
        tick();
        unit_resultRDY = 1'b0;
        wait_len = (lat == 0) ? TIMEOUT : lat;
        n        = (lat == 0) ? TIMEOUT + 1 : lat;
        for (int k = 1; k <= n; k++) begin
            if (restart && k == 3) begin
                start_mult = 1'b1;
                operand_a  = ~a;
                operand_b  = ~b;
                rd_in      = rd + 5'd1;
            end
            if (restart && k == 4) start_mult = 1'b0;
            if (k == lat) begin
                unit_resultRDY = 1'b1;
                unit_result    = res;
                unit_exception = exc;
            end
            @(negedge clock);
            if (k <= wait_len) begin
                chk("stall_in_wait", 64'(stall), 64'(1));
                chk("unit_a_held", 64'(unit_a), 64'(a));
                chk("unit_b_held", 64'(unit_b), 64'(b));
            end else begin
                chk("timeout_done_stall", 64'(stall), 64'(0));
            end
            tick();
            unit_resultRDY = 1'b0;
            unit_exception = 1'b0;
        end
        repeat (3) tick();
        chk("mult_pulses", 64'(mult_pulses), 64'(!is_div));
        chk("div_pulses", 64'(div_pulses), 64'(is_div));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m, d;
        int   lat;
        bit   rst_flag;
        reset = 1'b1;
        start_mult = 1'b0; start_div = 1'b0;
        operand_a = '0; operand_b = '0; rd_in = '0;
        unit_result = '0; unit_exception = 1'b0; unit_resultRDY = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        chk("outputs_zero_in_reset", 64'(any_out()), 64'(0));
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("outputs_zero_after_reset", 64'(any_out()), 64'(0));
        repeat (2) tick();

        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd5, 3, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'd9, 32'd0, 5'd3, 2, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd2, 1, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'd1234, 32'd5678, 5'd9, 6, 1'b1, 1'b1);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd11, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd0, 2, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 5'd31, TIMEOUT, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            m   = 1'($urandom_range(0, 1));
            d   = m ? 1'($urandom_range(0, 1)) : 1'b1;
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            rst_flag = (lat == 0 || lat >= 5) && ($urandom_range(0, 3) == 0);
            run_op(m, d, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                   5'($urandom), lat, 1'($urandom_range(0, 1)), rst_flag);
        end

        // Abort a multiply with reset in its tenth WAIT cycle.
        start_mult = 1'b1;
        operand_a  = 32'd21;
        operand_b  = 32'd2;
        rd_in      = 5'd7;
        tick();
        start_mult = 1'b0;
        tick();
        repeat (9) tick();
        reset = 1'b1;
        @(negedge clock);
        chk("abort_outputs_zero_in_reset", 64'(any_out()), 64'(0));
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_outputs_zero_after_reset", 64'(any_out()), 64'(0));
        tick();
        unit_resultRDY = 1'b1;
        unit_result    = 32'd42;
        tick();
        unit_resultRDY = 1'b0;
        repeat (5) tick();
        @(negedge clock);
        chk("abort_idle_outputs_zero", 64'(any_out()), 64'(0));
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
